// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants, fetch FSM states and buffer entry type.
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [6:0]  OPCODE_NOP       = 7'b000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response bus.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rvalid, rdata);
  modport slave(input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry {pc, instr} buffer, head always in slot 0.
module fetch_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  logic [1:0]   count;
  fetch_entry_t e0, e1;
  logic         do_pop;
  assign do_pop = pop && !empty;
  assign empty  = count == 2'd0;
  assign full   = count == 2'(DEPTH);
  assign head   = e0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      e0    <= '0;
      e1    <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(do_pop);
      if (do_pop) e0 <= e1;
      // a push lands in slot 0 whenever the shifted buffer would be empty
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && do_pop)) e0 <= din;
        else e1 <= din;
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect flush and 2-entry buffer.
module fetch_unit import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr
);
  fetch_state_t state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n, req_pc;
  logic         accept, push, full, empty;
  fetch_entry_t head;
  always_comb begin
    imem.req   = rst_n && state == ISSUE && !full && !redirect;
    imem.addr  = fetch_pc;
    accept     = imem.req && imem.ready;
    push       = state == WAIT && imem.rvalid && !redirect;
    fetch_pc_n = redirect ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc + 32'd4 : fetch_pc;
    // any response ends the outstanding request; a redirect while waiting turns it into a discard
    state_n    = state == ISSUE ? (accept ? WAIT : ISSUE) :
                 imem.rvalid ? ISSUE :
                 (state == WAIT && !redirect) ? WAIT : DISCARD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ISSUE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (accept) req_pc <= fetch_pc;
    end
  end
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (!stall),
    .clear (redirect),
    .din   ({req_pc, imem.rdata}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  assign if_valid = !empty;
  assign if_pc    = if_valid ? head.pc : 32'h0;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of entries in the instruction buffer; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rvalid  input  1  response data valid.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 stall  input  1  downstream decode/control stage cannot consume this cycle.
REQ-011 redirect  input  1  branch/JAL/JALR taken; flush and refetch.
REQ-012 redirect_pc  input  32  new fetch target.
REQ-013 if_valid  output  1  if_pc/if_instr hold a valid instruction.
REQ-014 if_pc  output  32  PC of the presented instruction.
REQ-015 if_instr  output  32  presented instruction; its opcode field [6:0] feeds the control decoder.

Function
REQ-016 A request SHALL be accepted in a cycle where imem_req and imem_ready are both 1; each accepted request SHALL receive exactly one in-order response (imem_rvalid), at least 1 cycle later.
REQ-017 At most one request SHALL be outstanding.
REQ-018 The FSM SHALL have states ISSUE (no request outstanding), WAIT (request outstanding, response to be kept) and DISCARD (request outstanding, response to be dropped).
REQ-019 In ISSUE, imem_req SHALL be 1 if and only if buffer occupancy < 2 and redirect = 0; imem_addr SHALL equal the fetch PC.
REQ-020 On acceptance, the FSM SHALL move ISSUE->WAIT, the fetch PC SHALL advance by 4 (mod 2^32, so 32'hFFFFFFFC wraps to 0), and the request PC SHALL be latched.
REQ-021 In WAIT, on imem_rvalid the FSM SHALL push {latched PC, imem_rdata} into the buffer and return to ISSUE; the next request SHALL be issued no earlier than the following cycle.
REQ-022 The buffer SHALL present its head on if_pc/if_instr with if_valid = (occupancy > 0).
REQ-023 The head SHALL be popped in any cycle where if_valid = 1 and stall = 0.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged; overflow SHALL be impossible because issue requires occupancy < 2.
REQ-025 When if_valid = 0, if_instr SHALL be 32'h00000000 (decodes as nop) and if_pc SHALL be 32'h00000000.
REQ-026 stall SHALL NOT block fetching; fetching continues until the buffer is full.
REQ-027 redirect SHALL have highest priority; it SHALL take effect in the same cycle it is asserted.
REQ-028 On redirect the buffer SHALL be cleared and the fetch PC SHALL load {redirect_pc[31:2], 2'b00}.
REQ-029 Redirect in WAIT without imem_rvalid SHALL go to DISCARD; redirect in WAIT with imem_rvalid SHALL drop that response and go to ISSUE.
REQ-030 In DISCARD, imem_rvalid SHALL be dropped and the FSM SHALL go to ISSUE; a redirect in DISCARD SHALL update the fetch PC and remain in DISCARD.
REQ-031 Redirect and pop in the same cycle SHALL result in an empty buffer; the pop is ignored.

Reset
REQ-032 While rst_n = 0: FSM = ISSUE, fetch PC = RESET_PC, buffer empty, imem_req = 0, if_valid = 0, if_pc = 0, if_instr = 0.
REQ-033 imem_req SHALL first assert in the first cycle after rst_n deasserts.
REQ-034 Reset asserted while a request is outstanding SHALL abandon it; the memory is reset by the same rst_n.

Structure
REQ-035 The shared package riscv_pkg SHALL hold: NOP_INSTR = 32'h00000000; OPCODE_NOP = 7'b0000000; the fetch FSM state enum; the default RESET_PC.
REQ-036 The 2-entry {pc, instr} buffer SHALL be the sub-module fetch_fifo, with push, pop, clear, full and empty.

Verification
REQ-037 Reset, then imem_ready = 1 with 1-cycle response latency, stall = 0 -> imem_addr = 0x0, 0x4, 0x8 in sequence; if_pc follows with matching imem_rdata.
REQ-038 stall held at 1 from reset -> exactly 2 requests (0x0, 0x4); imem_req = 0 afterwards; release stall -> 0x0 presented, then 0x4, then fetch resumes at 0x8.
REQ-039 redirect to 0x103 while WAIT on 0x8 -> response for 0x8 dropped; next imem_addr = 0x100; if_valid = 0 in between with if_instr = 0.
REQ-040 redirect in the same cycle as imem_rvalid -> data not presented; next imem_addr = target.
REQ-041 Fetch PC = 0xFFFFFFFC -> next request address = 0x00000000.
REQ-042 rst_n pulled low mid-WAIT -> all outputs are at their reset values immediately (asynchronously); first request after release is RESET_PC.
